mul_share_ctrl: RTL and testbench

Sequencer and arbiter that shares one iterative 32x32 shift-add multiplier core between two requesters, for example the ALU issue port and the address-generation unit.
- Accepts operand packets over valid/ready handshakes and picks the next requester by two-way round-robin.
- Launches the core, waits for its done pulse under a watchdog, and returns the 64-bit product with the requester id and tag.
- Sits between the issue logic and the multiplier datapath; one operation is in flight at a time.

---
 rtl/mul_ctrl_pkg.sv | 18 +
 rtl/mul_share_ctrl_rr_arb2.sv | 32 +++
 rtl/mul_share_ctrl.sv | 116 +++++++++++
 tb/tb_mul_share_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the multiplier-sharing controller: FSM states,
// signedness codes understood by the core, and the default watchdog limit.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] MUL_SS = 2'b00;
    localparam logic [1:0] MUL_SU = 2'b10;
    localparam logic [1:0] MUL_UU = 2'b11;

    localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/mul_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to
// the requester that was not granted most recently.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] request,
    input  logic       advance,
    output logic [1:0] grant
);

    // Remembers who won last; resetting to 1 hands the first tie to req0.
    logic last;

    always_comb begin
        grant = 2'b00;
        case (request)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one iterative multiplier core between two requesters: arbitrates,
// launches the core, guards it with a watchdog and returns the product.
module mul_share_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [1:0]       req0_sign,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [1:0]       req1_sign,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic [1:0]       mul_sign,
    output logic             mul_start,
    input  logic             mul_done,
    input  logic [31:0]      mul_lo,
    input  logic [31:0]      mul_hi,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_lo,
    output logic [31:0]      rsp_hi,
    output logic             rsp_err
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wdog;
    logic [1:0]       grant;
    logic             idle;

    assign idle = (state == S_IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .request ({req1_valid, req0_valid}),
        .advance (idle),
        .grant   (grant)
    );

    // Readys are held low while reset is asserted so every output reads 0.
    assign req0_ready = rst_n && idle && grant[0];
    assign req1_ready = rst_n && idle && grant[1];
    assign mul_start  = (state == S_LAUNCH);
    assign rsp_valid  = (state == S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wdog     <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_sign <= '0;
            rsp_id   <= 1'b0;
            rsp_tag  <= '0;
            rsp_lo   <= '0;
            rsp_hi   <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant != 2'b00) begin
                        mul_a    <= grant[1] ? req1_a    : req0_a;
                        mul_b    <= grant[1] ? req1_b    : req0_b;
                        mul_sign <= grant[1] ? req1_sign : req0_sign;
                        rsp_tag  <= grant[1] ? req1_tag  : req0_tag;
                        rsp_id   <= grant[1];
                        state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    wdog <= wdog + 1'b1;
                    // A completion in the expiry cycle still counts as success.
                    if (mul_done) begin
                        rsp_lo  <= mul_lo;
                        rsp_hi  <= mul_hi;
                        rsp_err <= 1'b0;
                        state   <= S_RESP;
                    end else if (wdog == WDOG_LAST) begin
                        rsp_lo  <= '0;
                        rsp_hi  <= '0;
                        rsp_err <= 1'b1;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl: a latency-34 core model, a
// transaction-level reference checked every cycle, and directed scenarios.
module tb_mul_share_ctrl;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;
    localparam int L       = 34;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]       req0_sign = '0, req1_sign = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic [31:0]      mul_a, mul_b;
    logic [1:0]       mul_sign;
    logic             mul_start;
    logic             mul_done;
    logic [31:0]      mul_lo, mul_hi;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_lo, rsp_hi;
    logic             rsp_err;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int          done_cyc = -1;
    int          stray_cyc = -1;
    bit          core_hang = 1'b0;
    logic [63:0] core_p = '0;

    mul_share_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sign  (req0_sign),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sign  (req1_sign),
        .req1_tag   (req1_tag),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_sign   (mul_sign),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .mul_lo     (mul_lo),
        .mul_hi     (mul_hi),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_lo     (rsp_lo),
        .rsp_hi     (rsp_hi),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Full 64-bit product with the signedness rules of the core.
    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                                input logic [1:0] s);
        logic [63:0] ea, eb;
        ea = (s == 2'b11) ? {32'd0, a} : {{32{a[31]}}, a};
        eb = s[1] ? {32'd0, b} : {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Core model: sees mul_start, answers L cycles later, junk on the bus otherwise.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mul_start) begin
                done_cyc = cyc + L;
                core_p   = ref_product(mul_a, mul_b, mul_sign);
            end
        end
    end

    initial begin
        mul_done = 1'b0;
        mul_lo   = '0;
        mul_hi   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc == stray_cyc || (cyc == done_cyc && !core_hang)) begin
                mul_done         = 1'b1;
                {mul_hi, mul_lo} = core_p;
            end else begin
                mul_done = 1'b0;
                mul_lo   = $urandom;
                mul_hi   = $urandom;
            end
        end
    end

    // Transaction-level reference: one operation at a time, timestamps only.
    initial begin
        bit          m_busy = 1'b0, m_last = 1'b1, m_have = 1'b0, m_id = 1'b0, m_err = 1'b0;
        bit          accept, pick, exp_r0, exp_r1, exp_valid;
        int          m_start = 0, m_rsp_cyc = 0;
        logic [31:0] m_a = '0, m_b = '0;
        logic [1:0]  m_sign = '0;
        logic [TAG_W-1:0] m_tag = '0;
        logic [63:0] m_prod = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_ctl", {req0_ready, req1_ready, mul_start, rsp_valid, rsp_err, rsp_id}, 0);
                chk("rst_mul", {mul_a, mul_b}, 0);
                chk("rst_rsp", {rsp_hi, rsp_lo}, 0);
                chk("rst_tag_sign", {rsp_tag, mul_sign}, 0);
                m_busy = 1'b0;
                m_last = 1'b1;
                continue;
            end
            accept = 1'b0;
            pick   = 1'b0;
            if (!m_busy && (req0_valid || req1_valid)) begin
                accept = 1'b1;
                pick   = (req0_valid && req1_valid) ? !m_last : req1_valid;
            end
            exp_r0 = accept && !pick;
            exp_r1 = accept && pick;
            chk("ready0", req0_ready, exp_r0);
            chk("ready1", req1_ready, exp_r1);
            chk("mul_start", mul_start, m_busy && cyc == m_start);
            if (m_busy && cyc >= m_start && !m_have) begin
                chk("mul_a", mul_a, m_a);
                chk("mul_b", mul_b, m_b);
                chk("mul_sign", mul_sign, m_sign);
            end
            exp_valid = m_busy && m_have && cyc >= m_rsp_cyc;
            chk("rsp_valid", rsp_valid, exp_valid);
            if (exp_valid) begin
                chk("rsp_prod", {rsp_hi, rsp_lo}, m_prod);
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_tag", rsp_tag, m_tag);
                chk("rsp_err", rsp_err, m_err);
            end
            if (m_busy && !m_have && cyc > m_start) begin
                if (mul_done) begin
                    m_have = 1'b1; m_rsp_cyc = cyc + 1; m_err = 1'b0;
                    m_prod = ref_product(m_a, m_b, m_sign);
                end else if (cyc == m_start + TIMEOUT) begin
                    m_have = 1'b1; m_rsp_cyc = cyc + 1; m_err = 1'b1; m_prod = '0;
                end
            end
            if (exp_valid && rsp_ready) m_busy = 1'b0;
            if (accept) begin
                m_busy  = 1'b1;
                m_have  = 1'b0;
                m_start = cyc + 1;
                m_last  = pick;
                m_id    = pick;
                m_a     = pick ? req1_a : req0_a;
                m_b     = pick ? req1_b : req0_b;
                m_sign  = pick ? req1_sign : req0_sign;
                m_tag   = pick ? req1_tag : req0_tag;
            end
        end
    end

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic wait_accept(input int id, output int t);
        t = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                t = cyc;
                break;
            end
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("[TB] FAIL accept_req%0d cycle %0d got no ready expected ready within 400", id, cyc);
            t = cyc;
        end
    endtask

    task automatic apply_stimulus(input int id, input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] s, input logic [TAG_W-1:0] tag);
        if (id == 0) begin
            req0_a = a; req0_b = b; req0_sign = s; req0_tag = tag; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_sign = s; req1_tag = tag; req1_valid = 1'b1;
        end
    endtask

    task automatic check_output(input string nm, input int at, input logic [63:0] prod,
                                input bit id, input logic [TAG_W-1:0] tag, input bit err);
        goto_cycle(at - 1);
        chk({nm, "_early"}, rsp_valid, 1'b0);
        goto_cycle(at);
        chk({nm, "_valid"}, rsp_valid, 1'b1);
        chk({nm, "_prod"}, {rsp_hi, rsp_lo}, prod);
        chk({nm, "_id"}, rsp_id, id);
        chk({nm, "_tag"}, rsp_tag, tag);
        chk({nm, "_err"}, rsp_err, err);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout cycle %0d got no finish expected finish", cyc);
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int t, h;
        int order[4];
        int n;

        repeat (3) drive_point();
        rsp_n_release: rst_n = 1'b1;

        // Single unsigned operation from req0, latency pinned by hand.
        drive_point();
        rsp_ready = 1'b1;
        apply_stimulus(0, 32'd3, 32'd5, 2'b11, 4'd2);
        wait_accept(0, t);
        drive_point();
        req0_valid = 1'b0;
        goto_cycle(t + 1);
        chk("t1_start", mul_start, 1'b1);
        check_output("t1", t + 36, 64'd15, 1'b0, 4'd2, 1'b0);

        // Signed -1 * 2 from req1; operands must sit still through WAIT.
        drive_point();
        apply_stimulus(1, 32'hFFFF_FFFF, 32'd2, 2'b00, 4'd7);
        wait_accept(1, t);
        drive_point();
        req1_valid = 1'b0;
        goto_cycle(t + 20);
        chk("t2_mul_a", mul_a, 32'hFFFF_FFFF);
        chk("t2_mul_b", mul_b, 32'd2);
        check_output("t2", t + 36, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'd7, 1'b0);

        // Both requesters always valid: grants must alternate starting at req0.
        drive_point();
        apply_stimulus(0, 32'd10, 32'd11, 2'b11, 4'd1);
        apply_stimulus(1, 32'd12, 32'd13, 2'b10, 4'd9);
        n = 0;
        for (int k = 0; k < 400 && n < 4; k++) begin
            @(negedge clk);
            if (req0_ready) begin order[n] = 0; n++; end
            else if (req1_ready) begin order[n] = 1; n++; end
        end
        chk("t3_grants", n, 4);
        chk("t3_g0", order[0], 0);
        chk("t3_g1", order[1], 1);
        chk("t3_g2", order[2], 0);
        chk("t3_g3", order[3], 1);
        drive_point();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        goto_cycle(cyc + 45);

        // Backpressure: response held for 10 cycles, req1 waits then wins.
        drive_point();
        rsp_ready = 1'b0;
        apply_stimulus(0, 32'd7, 32'd9, 2'b11, 4'd5);
        wait_accept(0, t);
        drive_point();
        req0_valid = 1'b0;
        apply_stimulus(1, 32'd1, 32'd1, 2'b11, 4'd3);
        for (int c = t + 36; c < t + 46; c++) begin
            goto_cycle(c);
            chk("t4_hold_valid", rsp_valid, 1'b1);
            chk("t4_hold_lo", rsp_lo, 32'd63);
            chk("t4_hold_ready1", req1_ready, 1'b0);
        end
        drive_point();
        rsp_ready = 1'b1;
        h = cyc;
        goto_cycle(h);
        chk("t4_no_grant_in_hs", req1_ready, 1'b0);
        goto_cycle(h + 1);
        chk("t4_grant_after", req1_ready, 1'b1);
        drive_point();
        req1_valid = 1'b0;
        goto_cycle(h + 45);

        // Hung core: watchdog error response, then a normal operation.
        drive_point();
        core_hang = 1'b1;
        apply_stimulus(0, 32'd11, 32'd13, 2'b11, 4'd4);
        wait_accept(0, t);
        drive_point();
        req0_valid = 1'b0;
        goto_cycle(t + 1);
        chk("t5_start", mul_start, 1'b1);
        check_output("t5", t + 1 + 65, 64'd0, 1'b0, 4'd4, 1'b1);
        drive_point();
        core_hang = 1'b0;
        apply_stimulus(1, 32'd6, 32'd7, 2'b11, 4'd8);
        wait_accept(1, t);
        drive_point();
        req1_valid = 1'b0;
        check_output("t5b", t + 36, 64'd42, 1'b1, 4'd8, 1'b0);

        // Reset in WAIT drops the operation; late and stray done pulses are ignored.
        drive_point();
        apply_stimulus(0, 32'd2, 32'd21, 2'b11, 4'd6);
        wait_accept(0, t);
        drive_point();
        req0_valid = 1'b0;
        goto_cycle(t + 10);
        drive_point();
        rst_n = 1'b0;
        drive_point();
        drive_point();
        rst_n = 1'b1;
        stray_cyc = t + 18;
        for (int c = t + 14; c <= t + 40; c++) begin
            goto_cycle(c);
            chk("t6_quiet", {rsp_valid, mul_start}, 2'b00);
        end
        drive_point();
        apply_stimulus(0, 32'd4, 32'd5, 2'b11, 4'd10);
        wait_accept(0, t);
        drive_point();
        req0_valid = 1'b0;
        goto_cycle(t + 1);
        chk("t6_start", mul_start, 1'b1);
        check_output("t6", t + 36, 64'd20, 1'b0, 4'd10, 1'b0);

        // Randomized traffic against the reference.
        for (int k = 0; k < 2500; k++) begin
            drive_point();
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a = $urandom; req0_b = $urandom; req0_sign = 2'($urandom_range(0, 3));
            req1_a = $urandom; req1_b = $urandom; req1_sign = 2'($urandom_range(0, 3));
            req0_tag = 4'($urandom_range(0, 15));
            req1_tag = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        drive_point();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        goto_cycle(cyc + 120);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
